// File: rtl/align_shamt_pipe.sv
// FMA exponent-difference stage: addend shift amount, product exponent,
// addend significand and effective-subtract flag, two-stage valid/ready pipe.
module align_shamt_pipe #(
  parameter int SIG_WIDTH    = 23,
  parameter int EXP_WIDTH    = 8,
  parameter int SHAMT_WIDTH  = 7,
  parameter int BIAS         = 127,
  parameter int SHIFT_OFFSET = 27,
  parameter int MAX_SHAMT    = 71
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sA,
  input  logic                   sB,
  input  logic                   sC,
  input  logic [EXP_WIDTH-1:0]   eA,
  input  logic [EXP_WIDTH-1:0]   eB,
  input  logic [EXP_WIDTH-1:0]   eC,
  input  logic [SIG_WIDTH-1:0]   fC,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIG_WIDTH:0]     C,
  output logic [SHAMT_WIDTH-1:0] shamt,
  output logic [EXP_WIDTH+1:0]   prod_exp,
  output logic                   eff_sub,
  output logic                   shamt_sat,
  output logic                   c_dom
);

  localparam int W = EXP_WIDTH + 3;
  localparam logic signed [W-1:0] L_BIAS = W'(BIAS);
  localparam logic signed [W-1:0] L_OFF  = W'(SHIFT_OFFSET);
  localparam logic signed [W-1:0] L_MAX  = W'(MAX_SHAMT);
  localparam logic [SHAMT_WIDTH-1:0] L_MAXSH = SHAMT_WIDTH'(MAX_SHAMT);

  // zero exponent behaves as 1 (denormal/zero)
  function automatic logic signed [W-1:0] fixup(
    input logic [EXP_WIDTH-1:0] e
  );
    return (e == '0) ? W'(1) : W'(e);
  endfunction

  logic signed [W-1:0]   w_pexp;
  logic signed [W-1:0]   w_d;
  logic                  w_accept;
  logic                  w_s2_load;
  logic                  w_cdom;
  logic                  w_sat;
  logic [SHAMT_WIDTH-1:0] w_shamt;

  logic                  r_s1_valid;
  logic signed [W-1:0]   r_s1_d;
  logic [EXP_WIDTH+1:0]  r_s1_pexp;
  logic [SIG_WIDTH:0]    r_s1_c;
  logic                  r_s1_sub;

  logic                  r_s2_valid;
  logic [SHAMT_WIDTH-1:0] r_s2_shamt;
  logic [EXP_WIDTH+1:0]  r_s2_pexp;
  logic [SIG_WIDTH:0]    r_s2_c;
  logic                  r_s2_sub;
  logic                  r_s2_sat;
  logic                  r_s2_cdom;

  assign w_pexp = fixup(eA) + fixup(eB) - L_BIAS;
  assign w_d    = w_pexp - fixup(eC) + L_OFF;

  assign w_s2_load = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | ~r_s2_valid | out_ready;
  assign w_accept  = in_valid & in_ready;

  assign w_cdom  = r_s1_d[W-1];
  assign w_sat   = r_s1_d > L_MAX;
  assign w_shamt = w_cdom ? '0 :
                   w_sat  ? L_MAXSH :
                   r_s1_d[SHAMT_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_d     <= '0;
      r_s1_pexp  <= '0;
      r_s1_c     <= '0;
      r_s1_sub   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_d     <= w_d;
      r_s1_pexp  <= w_pexp[EXP_WIDTH+1:0];
      r_s1_c     <= {|eC, fC};
      r_s1_sub   <= sA ^ sB ^ sC;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_shamt <= '0;
      r_s2_pexp  <= '0;
      r_s2_c     <= '0;
      r_s2_sub   <= 1'b0;
      r_s2_sat   <= 1'b0;
      r_s2_cdom  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_shamt <= w_shamt;
        r_s2_pexp  <= r_s1_pexp;
        r_s2_c     <= r_s1_c;
        r_s2_sub   <= r_s1_sub;
        r_s2_sat   <= w_sat;
        r_s2_cdom  <= w_cdom;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign C         = r_s2_c;
  assign shamt     = r_s2_shamt;
  assign prod_exp  = r_s2_pexp;
  assign eff_sub   = r_s2_sub;
  assign shamt_sat = r_s2_sat;
  assign c_dom     = r_s2_cdom;

endmodule

// File: tb/tb_align_shamt_pipe.sv
// Scoreboard bench for align_shamt_pipe: directed vectors with
// hand-computed results, stalls, reset flush and latency.
module tb_align_shamt_pipe;

  typedef struct {
    logic [23:0] c;
    logic [6:0]  sh;
    logic [9:0]  pe;
    logic        sub;
    logic        sat;
    logic        cd;
  } exp_t;

  typedef struct {
    logic       sa, sb, sc;
    logic [7:0] ea, eb, ec;
    logic [22:0] fc;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic sA = 0, sB = 0, sC = 0;
  logic [7:0] eA = 0, eB = 0, eC = 0;
  logic [22:0] fC = 0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [23:0] C;
  logic [6:0] shamt;
  logic [9:0] prod_exp;
  logic eff_sub, shamt_sat, c_dom;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  align_shamt_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sA(sA), .sB(sB), .sC(sC),
    .eA(eA), .eB(eB), .eC(eC), .fC(fC),
    .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .shamt(shamt), .prod_exp(prod_exp),
    .eff_sub(eff_sub), .shamt_sat(shamt_sat), .c_dom(c_dom)
  );

  function automatic vec_t mk(
    input logic sa, input logic sb, input logic sc,
    input int ea, input int eb, input int ec, input int fc,
    input int c, input int sh, input int pe,
    input logic sub, input logic sat, input logic cd
  );
    vec_t v;
    v.sa = sa; v.sb = sb; v.sc = sc;
    v.ea = 8'(ea); v.eb = 8'(eb); v.ec = 8'(ec);
    v.fc = 23'(fc);
    v.e.c = 24'(c); v.e.sh = 7'(sh); v.e.pe = 10'(pe);
    v.e.sub = sub; v.e.sat = sat; v.e.cd = cd;
    return v;
  endfunction

  task automatic check(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // monitor: pops one expectation per output transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got shamt %0d with empty queue", shamt);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({C, shamt, prod_exp, eff_sub, shamt_sat, c_dom} !==
            {e.c, e.sh, e.pe, e.sub, e.sat, e.cd}) begin
          errors++;
          $display("FAIL result: got C=%h sh=%0d pe=%h sub=%b sat=%b cd=%b want C=%h sh=%0d pe=%h sub=%b sat=%b cd=%b",
                   C, shamt, prod_exp, eff_sub, shamt_sat, c_dom,
                   e.c, e.sh, e.pe, e.sub, e.sat, e.cd);
        end
      end
    end
  end

  // entered and left at posedge+1
  task automatic send(input int k);
    logic ok;
    ok = 1'b0;
    sA = vecs[k].sa; sB = vecs[k].sb; sC = vecs[k].sc;
    eA = vecs[k].ea; eB = vecs[k].eb; eC = vecs[k].ec;
    fC = vecs[k].fc;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) q.push_back(vecs[k].e);
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 1'b0, 64'(k), 64'(k));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pat;
    pat = 32'hB6D3_5A9C;
    vecs[0] = mk(0,0,0, 127,127,127, 0,        'h800000, 27, 127,  0,0,0);
    vecs[1] = mk(0,0,0, 1,1,254,     'h123456, 'h923456, 0,  -125, 0,0,1);
    vecs[2] = mk(0,0,0, 200,200,0,   'h7FFFFF, 'h7FFFFF, 71, 273,  0,1,0);
    vecs[3] = mk(1,0,0, 100,100,100, 0,        'h800000, 0,  73,   1,0,0);
    vecs[4] = mk(0,0,1, 100,100,29,  1,        'h800001, 71, 73,   1,0,0);
    vecs[5] = mk(1,1,1, 100,100,28,  'h400000, 'hC00000, 71, 73,   1,1,0);
    vecs[6] = mk(1,1,0, 100,100,101, 0,        'h800000, 0,  73,   0,0,1);
    vecs[7] = mk(0,1,0, 0,0,0,       'hABC,    'h000ABC, 0,  -125, 1,0,1);
    vecs[8] = mk(0,0,0, 254,254,254, 'h7FFFFF, 'hFFFFFF, 71, 381,  0,1,0);
    vecs[9] = mk(0,1,1, 130,120,110, 'h0F0F0F, 'h8F0F0F, 40, 123,  0,0,0);

    #3;
    check("reset_out", out_valid == 0 && C == 0 && shamt == 0 &&
          prod_exp == 0 && {eff_sub, shamt_sat, c_dom} == 0,
          64'({out_valid, shamt, prod_exp}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", in_ready == 1'b1, 64'(in_ready), 64'(1));

    // latency: accept edge, then valid one edge later
    send(0);
    @(negedge clk);
    check("lat_early", out_valid == 1'b0, 64'(out_valid), 64'(0));
    @(negedge clk);
    check("lat_on_time", out_valid == 1'b1, 64'(out_valid), 64'(1));
    @(posedge clk); #1;

    for (int k = 1; k < 10; k++) send(k);
    idle(4);
    check("directed_drained", q.size() == 0, 64'(q.size()), 64'(0));

    fork
      for (int k = 0; k < 10; k++) send(k);
      begin
        for (int i = 0; i < 30; i++) begin
          out_ready = pat[i];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("random_ready_drained", q.size() == 0, 64'(q.size()), 64'(0));

    out_ready = 1'b0;
    fork
      begin send(0); send(1); send(2); send(3); end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_ready_low", in_ready == 1'b0, 64'(in_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
          check("bp_hold", out_valid == 1'b1 && shamt == 7'd27 &&
                C == 24'h800000 && prod_exp == 10'd127,
                64'({out_valid, shamt, C}), 64'({1'b1, 7'd27, 24'h800000}));
          if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("bp_drained", q.size() == 0, 64'(q.size()), 64'(0));

    out_ready = 1'b0;
    send(2);
    send(4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_flush", out_valid == 0 && C == 0 && shamt == 0 &&
          prod_exp == 0 && {eff_sub, shamt_sat, c_dom} == 0,
          64'({out_valid, shamt, C}), 64'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(5);
    @(negedge clk);
    check("rst_lat_early", out_valid == 1'b0, 64'(out_valid), 64'(0));
    @(negedge clk);
    check("rst_lat_on_time", out_valid == 1'b1, 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    idle(4);
    check("final_drained", q.size() == 0, 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
